// File: rtl/uart_tx_pkg.sv
// Shared baudgen divisor constants (12 MHz clock) and frame layout for uart_tx.
// Frame width grows by one parity bit when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B38400  = 312;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B9600   = 1250;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    // Shift-register image of one frame, bit 0 goes on the line first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// baudgen_tx: one-cycle tick at the end of every BAUD-cycle bit period.
// The divider is held at zero while clk_en is low so each frame starts phase-aligned.
module baudgen_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(BAUD - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = clk_en && (cnt_q == LAST);
        cnt_d = cnt_q + 16'd1;
        if (!clk_en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), BAUD clk cycles per bit.
// tx is the LSB of the frame shift register, so the line is always driven from a flop.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRANS    = 2'b01,
        STOPWAIT = 2'b10
    } state_t;

    // Bit count seen at the tick that ends the last non-stop bit.
    localparam logic [3:0] LAST_NONSTOP = 4'(FRAME_BITS - 2);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [3:0]              bitcnt_q, bitcnt_d;
    logic                    clk_en;
    logic                    tick;

    assign clk_en = (state_q == TRANS) || (state_q == STOPWAIT);
    assign ready  = (state_q == IDLE);
    assign tx     = shift_q[0];

    baudgen_tx #(
        .BAUD(BAUD)
    ) u_baudgen (
        .clk   (clk),
        .rstn  (rstn),
        .clk_en(clk_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                if (start) begin
                    state_d = TRANS;
                    shift_d = build_frame(data);
                end
            end
            TRANS: begin
                if (tick) begin
                    shift_d  = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == LAST_NONSTOP) begin
                        state_d = STOPWAIT;
                    end
                end
            end
            STOPWAIT: begin
                if (tick) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                shift_d  = '1;
                bitcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shift_q  <= '1;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at BAUD=4; expected line levels come from frame arithmetic.
// Build with UART_TX_PARITY_EN defined to exercise the 11-bit parity frame.
module tb_uart_tx;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int checks   = 0;
    int failures = 0;

    logic cap_tx[$];
    logic cap_rdy[$];

    uart_tx #(.BAUD(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .data (data),
        .tx   (tx),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // Level of frame bit idx: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic fbit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (FB == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // Expected line at sample k for one frame whose start bit begins at sample s.
    function automatic logic line_at(input int k, input int s, input logic [7:0] d);
        if (k >= s && k < s + FB * B) return fbit(d, (k - s) / B);
        return 1'b1;
    endfunction

    // Captured line level over a slot, or x if it was not steady for the whole slot.
    function automatic logic slot_level(input int from, input int len);
        logic v;
        v = cap_tx[from];
        for (int i = 1; i < len; i++) begin
            if (cap_tx[from + i] !== v) return 1'bx;
        end
        return v;
    endfunction

    function automatic int count_rdy(input int from, input int to, input logic v);
        int n = 0;
        for (int i = from; i < to; i++) begin
            if (cap_rdy[i] === v) n++;
        end
        return n;
    endfunction

    function automatic int count_tx_err(input int from, input int to, input int s, input logic [7:0] d);
        int n = 0;
        for (int i = from; i < to; i++) begin
            if (cap_tx[i] !== line_at(i, s, d)) n++;
        end
        return n;
    endfunction

    task automatic kick(input logic [7:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
    endtask

    task automatic sample;
        @(negedge clk);
        cap_tx.push_back(tx);
        cap_rdy.push_back(ready);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FB * B; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        rstn  = 1'b0;
        start = 1'b1;
        data  = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: ready=%b expected 1", ready); end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_after_reset: tx=%b ready=%b expected tx=0 ready=0", tx, ready);
        end
        start = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_idle_timeout: ready=%b expected 1", ready); end
    endtask

    task automatic test_frame(input logic [7:0] d, input logic [7:0] nd, input string name);
        int   n = FB * B;
        logic obs;
        cap_tx.delete();
        cap_rdy.delete();
        kick(d);
        for (int k = 0; k <= n; k++) begin
            sample();
            if (k == 0) begin
                start = 1'b0;
                data  = nd;
            end
        end
        for (int i = 0; i < FB; i++) begin
            obs = slot_level(i * B, B);
            checks++;
            if (obs !== fbit(d, i)) begin
                failures++;
                $display("FAIL %s bit%0d: tx=%b expected %b", name, i, obs, fbit(d, i));
            end
        end
        checks++;
        if (count_rdy(0, n, 1'b0) !== n) begin
            failures++;
            $display("FAIL %s ready_low: cycles=%0d expected %0d", name, count_rdy(0, n, 1'b0), n);
        end
        checks++;
        if (cap_rdy[n] !== 1'b1 || cap_tx[n] !== 1'b1) begin
            failures++;
            $display("FAIL %s end_idle: ready=%b tx=%b expected 1 1", name, cap_rdy[n], cap_tx[n]);
        end
    endtask

    task automatic test_single;
        test_frame(8'hA5, 8'hA5, "a5");
    endtask

    task automatic test_data_change;
        test_frame(8'h81, 8'hFF, "data_change");
    endtask

    task automatic test_parity;
        test_frame(8'h07, 8'h07, "parity07");
        test_frame(8'h03, 8'h03, "parity03");
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            test_frame(8'($urandom), 8'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back;
        int n = FB * B;
        int p = FB * B + 1;
        int e;
        cap_tx.delete();
        cap_rdy.delete();
        kick(8'h00);
        for (int k = 0; k <= p + n; k++) begin
            sample();
            if (k == 0) data = 8'hFF;
            if (k == p) start = 1'b0;
        end
        e = count_tx_err(0, p, 0, 8'h00);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL b2b_frame1: bad_cycles=%0d expected 0", e); end
        e = count_tx_err(p, p + n + 1, p, 8'hFF);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL b2b_frame2: bad_cycles=%0d expected 0", e); end
        checks++;
        if (cap_tx[p - 1] !== 1'b1 || cap_tx[p] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_start: tx[%0d]=%b tx[%0d]=%b expected 1 0", p - 1, cap_tx[p - 1], p, cap_tx[p]);
        end
        checks++;
        if (count_rdy(0, p + n, 1'b1) !== 1 || cap_rdy[n] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_gap: high_cycles=%0d expected 1", count_rdy(0, p + n, 1'b1));
        end
    endtask

    task automatic test_ignore_start;
        int         n = FB * B;
        int         len = FB * B + 3 * B;
        logic [7:0] d = 8'($urandom);
        int         e;
        cap_tx.delete();
        cap_rdy.delete();
        kick(d);
        for (int k = 0; k < len; k++) begin
            sample();
            if (k == 0) start = 1'b0;
            if (k == 10) begin start = 1'b1; data = 8'h3C; end
            if (k == 11) start = 1'b0;
        end
        e = count_tx_err(0, len, 0, d);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL ignore_line: bad_cycles=%0d expected 0", e); end
        checks++;
        if (count_rdy(n, len, 1'b1) !== len - n) begin
            failures++;
            $display("FAIL ignore_no_second: ready_high=%0d expected %0d", count_rdy(n, len, 1'b1), len - n);
        end
    endtask

    task automatic test_reset_midframe;
        int n = FB * B;
        int e;
        cap_tx.delete();
        cap_rdy.delete();
        kick(8'h55);
        for (int k = 0; k <= 18 + n; k++) begin
            sample();
            if (k == 0) start = 1'b0;
            if (k == 17) rstn = 1'b0;
            if (k == 18) rstn = 1'b1;
        end
        e = count_tx_err(0, 18, 0, 8'h55);
        checks++;
        if (e !== 0) begin failures++; $display("FAIL midrst_before: bad_cycles=%0d expected 0", e); end
        checks++;
        if (cap_tx[18] !== 1'b1 || cap_rdy[18] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_next: tx=%b ready=%b expected 1 1", cap_tx[18], cap_rdy[18]);
        end
        e = 0;
        for (int k = 18; k <= 18 + n; k++) begin
            if (cap_tx[k] !== 1'b1 || cap_rdy[k] !== 1'b1) e++;
        end
        checks++;
        if (e !== 0) begin failures++; $display("FAIL midrst_quiet: bad_cycles=%0d expected 0", e); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim_time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_start();
        test_reset_midframe();
        test_data_change();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD, default 104, meaning clk cycles per bit (115200 baud at 12 MHz), legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  transmit request, level-sampled each cycle.
REQ-005 SHALL have port data  input  8  byte to send, sampled only on the accept cycle.
REQ-006 SHALL have port tx  output  1  serial line, idle high, driven from a flop.
REQ-007 SHALL have port ready  output  1  high when a new start will be accepted.

Function
REQ-008 SHALL send each frame as one start bit (0), 8 data bits LSB first, optional parity bit (REQ-022), one stop bit (1).
REQ-009 SHALL hold each bit on tx for exactly BAUD clk cycles.
REQ-010 SHALL accept a request on any cycle with start=1 and ready=1, and SHALL latch data into a 10-bit (11 with parity) shift register on that cycle.
REQ-011 SHALL drive tx low on the first cycle after acceptance, i.e. 1-cycle latency.
REQ-012 SHALL deassert ready on the first cycle after acceptance and keep it low until the stop bit has completed its full BAUD cycles.
REQ-013 SHALL ignore start while ready=0, with no queuing and no corruption of the frame in flight.
REQ-014 SHALL not be affected by changes on data after the accept cycle.
REQ-015 SHALL implement states IDLE, TRANS and STOPWAIT:
- IDLE goes to TRANS on accept.
- TRANS shifts on each baud tick and goes to STOPWAIT once the last non-stop bit completes.
- STOPWAIT goes to IDLE after the stop bit's BAUD cycles.
- Any undefined encoding goes to IDLE.
REQ-016 SHALL restart the baud divider on accept, so bit 0 lasts exactly BAUD cycles with no phase carry-over.
REQ-017 SHALL count bits with a 4-bit counter cleared in IDLE, incremented on each baud tick, with no wrap within a frame.
REQ-018 SHALL keep ready=1 for at least one cycle between frames; with start held high, the next start bit begins 1 cycle after ready rises, giving a frame period of 10*BAUD+1 cycles (11*BAUD+1 with parity).

Reset
REQ-019 SHALL, on clk edge with rstn=0, set state=IDLE, tx=1, ready=1, shift register all ones, bit counter=0 and baud divider=0.
REQ-020 SHALL, on reset asserted mid-frame, abort the frame, drive tx=1 on the next cycle and not resume the frame.
REQ-021 SHALL ignore start during reset and accept it on the first cycle with rstn=1.

Configuration
REQ-022 SHALL, when UART_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) between bit 7 and stop, making the frame 11 bits; without the macro, the frame SHALL be 10 bits with no parity logic synthesized.

Structure
REQ-023 SHALL take baud divisor constants (B115200, B57600, B38400, B19200, B9600, ...) from the team's shared baudgen constants header/package; the state encodings SHALL be local constants.
REQ-024 SHALL instantiate one sub-module, baudgen_tx (BAUD parameter, clk_en input, 1-cycle tick output at end of each bit period, divider cleared while clk_en=0).

Verification
REQ-025 SHALL cover: BAUD=4, start pulse with data=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; ready low 40 cycles; tx falls 1 cycle after accept.
REQ-026 SHALL cover: BAUD=4, start held high, data 8'h00 then 8'hFF -> two frames, second start bit 41 cycles after the first, ready high exactly 1 cycle between them.
REQ-027 SHALL cover: start pulsed at cycle 10 of a frame with data=8'h3C -> ignored, in-flight frame bit-exact, no second frame.
REQ-028 SHALL cover: rstn low at cycle 17 of an 8'h55 frame -> tx=1, ready=1 next cycle, no further line toggling until a new start.
REQ-029 SHALL cover: UART_TX_PARITY_EN defined, data=8'h07 -> parity bit 1 after bit 7, frame 44 cycles at BAUD=4; data=8'h03 -> parity bit 0.
REQ-030 SHALL cover: data changed to 8'hFF one cycle after accepting 8'h81 -> transmitted bits match 8'h81.
